// File: rtl/neander_pkg.sv
// Shared definitions for the Neander control path: opcodes, ULA operation codes,
// control-unit state encoding and the bundle of control strobes.
package neander_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ULA_ADD  = 3'd0,
    ULA_AND  = 3'd1,
    ULA_OR   = 3'd2,
    ULA_NOT  = 3'd3,
    ULA_PASS = 3'd4
  } ula_op_t;

  typedef enum logic [3:0] {
    ST_F0   = 4'd0,
    ST_F1   = 4'd1,
    ST_F2   = 4'd2,
    ST_DEC  = 4'd3,
    ST_A0   = 4'd4,
    ST_A1   = 4'd5,
    ST_A2   = 4'd6,
    ST_X0   = 4'd7,
    ST_X1   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  typedef struct packed {
    logic is_mem;    // STA/LDA/ADD/OR/AND: operand address follows the opcode
    logic is_store;
    logic is_jump;
    logic is_alu;    // instructions that write AC from memory data
    logic is_halt;
    logic is_not;
  } op_class_t;

  typedef struct packed {
    logic    pc_inc;
    logic    pc_load;
    logic    mar_sel;
    logic    mar_load;
    logic    ri_load;
    logic    ac_load;
    logic    nz_load;
    ula_op_t ula_op;
    logic    mem_we;
    logic    halt;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    pc_inc: 1'b0, pc_load: 1'b0, mar_sel: 1'b0, mar_load: 1'b0, ri_load: 1'b0,
    ac_load: 1'b0, nz_load: 1'b0, ula_op: ULA_PASS, mem_we: 1'b0, halt: 1'b0
  };

  // Conditional jumps only branch when their flag is set; JMP always branches.
  function automatic logic jump_taken(input logic [3:0] op, input logic n, input logic z);
    return (op == OP_JMP) || ((op == OP_JN) && n) || ((op == OP_JZ) && z);
  endfunction

endpackage

// File: rtl/neander_decoder.sv
// Combinational opcode decoder: instruction class flags and the ULA operation
// used when the instruction writes AC.
module neander_decoder
  import neander_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_t  op_class,
  output ula_op_t    ula_op
);

  always_comb begin
    op_class = '0;
    ula_op   = ULA_PASS;
    case (opcode)
      OP_STA: begin
        op_class.is_mem   = 1'b1;
        op_class.is_store = 1'b1;
      end
      OP_LDA: begin
        op_class.is_mem = 1'b1;
        op_class.is_alu = 1'b1;
        ula_op          = ULA_PASS;
      end
      OP_ADD: begin
        op_class.is_mem = 1'b1;
        op_class.is_alu = 1'b1;
        ula_op          = ULA_ADD;
      end
      OP_OR: begin
        op_class.is_mem = 1'b1;
        op_class.is_alu = 1'b1;
        ula_op          = ULA_OR;
      end
      OP_AND: begin
        op_class.is_mem = 1'b1;
        op_class.is_alu = 1'b1;
        ula_op          = ULA_AND;
      end
      OP_NOT: begin
        op_class.is_not = 1'b1;
        ula_op          = ULA_NOT;
      end
      OP_JMP, OP_JN, OP_JZ: op_class.is_jump = 1'b1;
      OP_HLT:               op_class.is_halt = 1'b1;
      default: ;  // NOP and unassigned opcodes do nothing
    endcase
  end

endmodule

// File: rtl/neander_control.sv
// Neander control unit: Moore-style fetch/decode/execute sequencer with
// combinational strobes. Defining NEANDER_STEP_EN adds i_step single-stepping.
module neander_control
  import neander_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_opcode,
  input  logic       i_n,
  input  logic       i_z,
`ifdef NEANDER_STEP_EN
  input  logic       i_step,
`endif
  output logic       o_pc_inc,
  output logic       o_pc_load,
  output logic       o_mar_sel,
  output logic       o_mar_load,
  output logic       o_ri_load,
  output logic       o_ac_load,
  output logic       o_nz_load,
  output logic [2:0] o_ula_op,
  output logic       o_mem_we,
  output logic       o_halt
);

  state_t    state_reg;
  state_t    state_next;
  op_class_t op_class;
  ula_op_t   dec_ula_op;
  ctrl_t     ctrl;
  ctrl_t     ctrl_out;
  logic      step_ok;
  logic      taken;

`ifdef NEANDER_STEP_EN
  assign step_ok = i_step;
`else
  assign step_ok = 1'b1;
`endif

  neander_decoder u_decoder (
    .opcode   (i_opcode),
    .op_class (op_class),
    .ula_op   (dec_ula_op)
  );

  assign taken = jump_taken(i_opcode, i_n, i_z);

  always_ff @(posedge i_clk) begin
    if (!i_rst) state_reg <= ST_F0;
    else        state_reg <= state_next;
  end

  always_comb begin
    ctrl       = CTRL_IDLE;
    state_next = state_reg;
    case (state_reg)
      ST_F0: begin
        if (step_ok) begin
          ctrl.mar_load = 1'b1;
          state_next    = ST_F1;
        end else begin
          ctrl = '0;
        end
      end
      ST_F1: begin
        ctrl.pc_inc = 1'b1;
        state_next  = ST_F2;
      end
      ST_F2: begin
        ctrl.ri_load = 1'b1;
        state_next   = ST_DEC;
      end
      ST_DEC: begin
        state_next = ST_F0;
        if (op_class.is_not) begin
          ctrl.ula_op  = ULA_NOT;
          ctrl.ac_load = 1'b1;
          ctrl.nz_load = 1'b1;
        end else if (op_class.is_halt) begin
          state_next = ST_HALT;
        end else if (op_class.is_mem || taken) begin
          state_next = ST_A0;
        end else if (op_class.is_jump) begin
          // untaken conditional jump: step PC past the unused operand byte
          ctrl.pc_inc = 1'b1;
        end
      end
      ST_A0: begin
        ctrl.mar_load = 1'b1;
        state_next    = ST_A1;
      end
      ST_A1: begin
        ctrl.pc_inc = op_class.is_mem;
        state_next  = ST_A2;
      end
      ST_A2: begin
        if (op_class.is_jump) begin
          ctrl.pc_load = 1'b1;
          state_next   = ST_F0;
        end else begin
          ctrl.mar_sel  = 1'b1;
          ctrl.mar_load = 1'b1;
          state_next    = ST_X0;
        end
      end
      ST_X0: begin
        if (op_class.is_store) begin
          ctrl.mem_we = 1'b1;
          state_next  = ST_F0;
        end else begin
          state_next = ST_X1;
        end
      end
      ST_X1: begin
        ctrl.ula_op  = dec_ula_op;
        ctrl.ac_load = op_class.is_alu;
        ctrl.nz_load = op_class.is_alu;
        state_next   = ST_F0;
      end
      ST_HALT: begin
        ctrl.halt = 1'b1;
      end
      default: state_next = ST_F0;
    endcase
  end

  // Reset overrides every strobe so an aborted instruction cannot write anything.
  assign ctrl_out = i_rst ? ctrl : '0;

  assign o_pc_inc   = ctrl_out.pc_inc;
  assign o_pc_load  = ctrl_out.pc_load;
  assign o_mar_sel  = ctrl_out.mar_sel;
  assign o_mar_load = ctrl_out.mar_load;
  assign o_ri_load  = ctrl_out.ri_load;
  assign o_ac_load  = ctrl_out.ac_load;
  assign o_nz_load  = ctrl_out.nz_load;
  assign o_ula_op   = ctrl_out.ula_op;
  assign o_mem_we   = ctrl_out.mem_we;
  assign o_halt     = ctrl_out.halt;

endmodule

// File: tb/tb_neander_control.sv
// Scoreboard bench for neander_control: each instruction's expected per-cycle
// strobe pattern is queued from the instruction timing rules and checked every cycle.
module tb_neander_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       n = 1'b0;
  logic       z = 1'b0;
`ifdef NEANDER_STEP_EN
  logic       step = 1'b1;
`endif

  logic       pc_inc, pc_load, mar_sel, mar_load, ri_load, ac_load, nz_load, mem_we, halt;
  logic [2:0] ula_op;

  neander_control dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_opcode   (opcode),
    .i_n        (n),
    .i_z        (z),
`ifdef NEANDER_STEP_EN
    .i_step     (step),
`endif
    .o_pc_inc   (pc_inc),
    .o_pc_load  (pc_load),
    .o_mar_sel  (mar_sel),
    .o_mar_load (mar_load),
    .o_ri_load  (ri_load),
    .o_ac_load  (ac_load),
    .o_nz_load  (nz_load),
    .o_ula_op   (ula_op),
    .o_mem_we   (mem_we),
    .o_halt     (halt)
  );

  always #5 clk = ~clk;

  // bit order: pc_inc pc_load mar_sel mar_load ri_load ac_load nz_load ula[2:0] mem_we halt
  typedef struct {
    logic [11:0] v;
    logic [3:0]  op;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  wire [11:0] got = {pc_inc, pc_load, mar_sel, mar_load, ri_load, ac_load, nz_load,
                     ula_op, mem_we, halt};

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (got !== e.v) begin
        failures++;
        $display("FAIL strobes op=%h cycle=%0d got=%b expected=%b", e.op, e.cyc, got, e.v);
      end else begin
        $display("op=%h cycle=%0d strobes=%b ok", e.op, e.cyc, got);
      end
      checks++;
      if (pc_inc === 1'b1 && pc_load === 1'b1) begin
        failures++;
        $display("FAIL pc_exclusive op=%h cycle=%0d got=both required=not both", e.op, e.cyc);
      end
    end
  end

  task automatic push(input logic [11:0] v, input logic [3:0] op, input int cyc);
    exp_t e;
    e.v = v;
    e.op = op;
    e.cyc = cyc;
    q.push_back(e);
  endtask

  // Expected strobes for one instruction, derived from the instruction timing table.
  task automatic run_instr(input logic [3:0] op, input bit nn, input bit zz,
                           input int halt_cycles, input int limit);
    logic [11:0] base, v;
    bit mem, taken, untaken;
    int len, nrun;
    base = 12'b0;
    base[4:2] = 3'd4;
    mem = (op >= 4'h1 && op <= 4'h5);
    taken = (op == 4'h8) || (op == 4'h9 && nn) || (op == 4'hA && zz);
    untaken = (op == 4'h9 && !nn) || (op == 4'hA && !zz);
    len = mem ? ((op == 4'h1) ? 8 : 9) : (taken ? 7 : 4);
    nrun = (len < limit) ? len : limit;
    opcode = op;
    n = nn;
    z = zz;
    for (int i = 1; i <= nrun; i++) begin
      v = base;
      case (i)
        1: v[8] = 1'b1;
        2: v[11] = 1'b1;
        3: v[7] = 1'b1;
        4: begin
          if (op == 4'h6) begin
            v[6] = 1'b1;
            v[5] = 1'b1;
            v[4:2] = 3'd3;
          end else if (untaken) begin
            v[11] = 1'b1;
          end
        end
        5: v[8] = 1'b1;
        6: v[11] = mem;
        7: begin
          if (taken) v[10] = 1'b1;
          else begin
            v[9] = 1'b1;
            v[8] = 1'b1;
          end
        end
        8: v[1] = (op == 4'h1);
        default: begin
          v[6] = 1'b1;
          v[5] = 1'b1;
          case (op)
            4'h3:    v[4:2] = 3'd0;
            4'h4:    v[4:2] = 3'd2;
            4'h5:    v[4:2] = 3'd1;
            default: v[4:2] = 3'd4;
          endcase
        end
      endcase
      push(v, op, i);
    end
    if (op == 4'hF && nrun == len) begin
      v = base;
      v[0] = 1'b1;
      for (int i = 1; i <= halt_cycles; i++) push(v, op, len + i);
      nrun = nrun + halt_cycles;
    end
    repeat (nrun) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b0;
    for (int i = 1; i <= ncyc; i++) push(12'b0, opcode, -i);
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

`ifdef NEANDER_STEP_EN
  task automatic stall(input int ncyc);
    step = 1'b0;
    for (int i = 1; i <= ncyc; i++) push(12'b0, opcode, -i);
    repeat (ncyc) @(posedge clk);
    #1;
    step = 1'b1;
  endtask
`endif

  initial begin
    logic [3:0] op;
    @(posedge clk);
    #1;
    do_reset(3);
    run_instr(4'h0, 0, 0, 0, 99);
    run_instr(4'h7, 0, 0, 0, 99);
    run_instr(4'h2, 0, 0, 0, 99);
    run_instr(4'h3, 1, 0, 0, 99);
    run_instr(4'h1, 0, 1, 0, 99);
    run_instr(4'h9, 0, 1, 0, 99);
    run_instr(4'h9, 1, 0, 0, 99);
    run_instr(4'hA, 1, 0, 0, 99);
    run_instr(4'hA, 0, 1, 0, 99);
    run_instr(4'h8, 0, 0, 0, 99);
    run_instr(4'h6, 1, 1, 0, 99);
    run_instr(4'h4, 0, 0, 0, 99);
    run_instr(4'h5, 0, 0, 0, 99);
    run_instr(4'hC, 1, 1, 0, 99);
    // abort an LDA while it sits in its last cycle, holding reset for 3 cycles
    run_instr(4'h2, 0, 0, 0, 8);
    do_reset(3);
    run_instr(4'h1, 0, 0, 0, 7);
    do_reset(1);
    run_instr(4'hF, 0, 0, 20, 99);
    do_reset(2);
`ifdef NEANDER_STEP_EN
    stall(5);
    run_instr(4'h2, 0, 0, 0, 99);
    stall(1);
    run_instr(4'h9, 1, 0, 0, 99);
`endif
    for (int k = 0; k < 150; k++) begin
      op = 4'($urandom_range(0, 15));
`ifdef NEANDER_STEP_EN
      if ($urandom_range(0, 3) == 0) stall(int'($urandom_range(1, 3)));
`endif
      run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3, 99);
      if (op == 4'hF) do_reset(1);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
